sudoku_board_ctrl: RTL

SUDOKU_BOARD_CTRL -- requirements
Module: sudoku_board_ctrl

---
 rtl/sudoku_board_ctrl_if.sv | 8 +
 rtl/sudoku_board_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/sudoku_board_ctrl_if.sv
// sudoku_board_ctrl_if: load and player-write handshake between a game front end and the board controller.
interface sudoku_board_ctrl_if;
  logic load_req, load_done;
  logic wr_req, wr_ack, wr_ok, wr_err;
  logic [3:0] wr_x, wr_y, wr_num;
  modport master(output load_req, wr_req, wr_x, wr_y, wr_num, input load_done, wr_ack, wr_ok, wr_err);
  modport slave(input load_req, wr_req, wr_x, wr_y, wr_num, output load_done, wr_ack, wr_ok, wr_err);
endinterface

// File: rtl/sudoku_board_ctrl.sv
// sudoku_board_ctrl: loads a puzzle one cell per cycle, judges player entries, rescans revealed cells for win.
module sudoku_board_ctrl #(
  parameter int MAX_STRIKES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  sudoku_board_ctrl_if.slave   bus,
  input  logic [404:0]         selected_map,
  output logic [404:0]         board,
  output logic                 busy,
  output logic [6:0]           filled_count,
  output logic [2:0]           strikes,
  output logic                 win,
  output logic                 lose
);
  typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;
  state_t state;
  logic [6:0] idx, cnt, cnt_nxt;
  logic [9:0] ipos, wpos;
  logic [4:0] tgt;
  logic wr_in, judged;
  always_comb begin
    ipos = 10'(idx) * 10'd5;
    wpos = 10'(bus.wr_y) * 10'd45 + 10'(bus.wr_x) * 10'd5;
    wr_in = bus.wr_x < 4'd9 && bus.wr_y < 4'd9;
    tgt = wr_in ? board[wpos +: 5] : 5'd0;
    judged = !win && !lose && wr_in && !tgt[4];
    cnt_nxt = cnt + 7'(board[ipos + 10'd4]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      board <= '0;
      idx <= '0;
      cnt <= '0;
      filled_count <= '0;
      strikes <= '0;
      win <= 1'b0;
      lose <= 1'b0;
      busy <= 1'b0;
      bus.wr_ack <= 1'b0;
      bus.wr_ok <= 1'b0;
      bus.wr_err <= 1'b0;
      bus.load_done <= 1'b0;
    end else begin
      bus.wr_ack <= 1'b0;
      bus.wr_ok <= 1'b0;
      bus.wr_err <= 1'b0;
      bus.load_done <= 1'b0;
      case (state)
        IDLE:
          if (bus.load_req) begin
            state <= LOAD;
            busy <= 1'b1;
            idx <= '0;
            strikes <= '0;
            win <= 1'b0;
            lose <= 1'b0;
          end else if (bus.wr_req && !bus.wr_ack) begin
            bus.wr_ack <= 1'b1;
            if (judged && bus.wr_num == tgt[3:0]) begin
              board[wpos + 10'd4] <= 1'b1;
              bus.wr_ok <= 1'b1;
              state <= SCAN;
              busy <= 1'b1;
              idx <= '0;
              cnt <= '0;
            end else begin
              bus.wr_err <= 1'b1;
              // lose blocks further judged writes, so strikes cannot pass MAX_STRIKES
              if (judged) begin
                strikes <= strikes + 3'd1;
                lose <= strikes + 3'd1 == 3'(MAX_STRIKES);
              end
            end
          end
        LOAD: begin
          board[ipos +: 5] <= selected_map[ipos +: 5];
          if (idx == 7'd80) begin
            bus.load_done <= 1'b1;
            state <= SCAN;
            idx <= '0;
            cnt <= '0;
          end else idx <= idx + 7'd1;
        end
        SCAN:
          if (bus.load_req) begin
            state <= LOAD;
            idx <= '0;
            strikes <= '0;
            win <= 1'b0;
            lose <= 1'b0;
          end else if (idx == 7'd80) begin
            filled_count <= cnt_nxt;
            win <= cnt_nxt == 7'd81;
            state <= IDLE;
            busy <= 1'b0;
            idx <= '0;
          end else begin
            idx <= idx + 7'd1;
            cnt <= cnt_nxt;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
